reg_xfer_sequencer: RTL and testbench

Control sequencer that drives the 16-entry, 32-bit general register file and its bus multiplexer. It accepts one register-level command at a time: register MOVE, or a three-step ALU operation Rc = Ra op Rb through the Y/Z holding registers. It emits one-hot register-out (bus source) and register-in (write enable) strobes plus the Y/Z/ALU controls, and sits between the instruction-level control unit and the R0in..R15in / bus-select inputs of the datapath.

---
 rtl/reg_xfer_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_reg_xfer_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_xfer_sequencer.sv
// reg_xfer_sequencer
// Register-level transfer sequencer for a general register file and its bus
// multiplexer. It runs one command at a time, either a register MOVE or a
// three-step ALU operation Rc = Ra op Rb through the Y/Z holding registers.
// It emits one-hot bus-source and write-enable strobes plus the Y/Z/ALU
// controls.
//
// Ports
//   i_clock       single clock, rising edge
//   i_clear       synchronous active-high reset
//   i_start       command request, sampled only in IDLE
//   i_cmd         00 NOP, 01 MOVE, 10 ALU, 11 reserved
//   i_ra/i_rb/i_rc source A, source B and destination register indices
//   i_op_in       ALU opcode
//   o_busy        command in progress
//   o_done        one-cycle completion pulse
//   o_cmd_err     one-cycle pulse for the reserved command
//   o_r_out       one-hot bus source select
//   o_r_in        one-hot register write enable
//   o_y_in        load Y from the bus
//   o_z_in        load Z from the ALU result
//   o_z_low_out   Z low word drives the bus
//   o_alu_op      opcode presented to the ALU, zero outside AL_B
//
// State   | meaning
// --------+--------------------------------------------
// IDLE    | waiting for start, all outputs low
// MV      | Ra drives the bus, Rc loads from the bus
// AL_A    | Ra drives the bus, Y loads
// AL_B    | Rb drives the bus, ALU runs, Z loads
// AL_C    | Z low word drives the bus, Rc loads
// DONE    | completion pulse, cmd_err for reserved command
module reg_xfer_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4,
    parameter int OP_W     = 4
) (
    input  logic                i_clock,
    input  logic                i_clear,
    input  logic                i_start,
    input  logic [1:0]          i_cmd,
    input  logic [IDX_W-1:0]    i_ra,
    input  logic [IDX_W-1:0]    i_rb,
    input  logic [IDX_W-1:0]    i_rc,
    input  logic [OP_W-1:0]     i_op_in,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_cmd_err,
    output logic [NUM_REGS-1:0] o_r_out,
    output logic [NUM_REGS-1:0] o_r_in,
    output logic                o_y_in,
    output logic                o_z_in,
    output logic                o_z_low_out,
    output logic [OP_W-1:0]     o_alu_op
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MV,
        S_AL_A,
        S_AL_B,
        S_AL_C,
        S_DONE
    } state_t;

    state_t r_state, w_state_nxt;

    logic [1:0]       r_cmd, w_cmd_nxt;
    logic [IDX_W-1:0] r_ra, w_ra_nxt;
    logic [IDX_W-1:0] r_rb, w_rb_nxt;
    logic [IDX_W-1:0] r_rc, w_rc_nxt;
    logic [OP_W-1:0]  r_op, w_op_nxt;

    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_cmd_err, w_cmd_err_nxt;
    logic [NUM_REGS-1:0] r_r_out, w_r_out_nxt;
    logic [NUM_REGS-1:0] r_r_in, w_r_in_nxt;
    logic                r_y_in, w_y_in_nxt;
    logic                r_z_in, w_z_in_nxt;
    logic                r_z_low_out, w_z_low_out_nxt;
    logic [OP_W-1:0]     r_alu_op, w_alu_op_nxt;

    // Out-of-range indices match no bit and give an all-zero strobe.
    function automatic logic [NUM_REGS-1:0] f_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(idx) == i) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_nxt       = r_cmd;
        w_ra_nxt        = r_ra;
        w_rb_nxt        = r_rb;
        w_rc_nxt        = r_rc;
        w_op_nxt        = r_op;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_cmd_err_nxt   = 1'b0;
        w_r_out_nxt     = '0;
        w_r_in_nxt      = '0;
        w_y_in_nxt      = 1'b0;
        w_z_in_nxt      = 1'b0;
        w_z_low_out_nxt = 1'b0;
        w_alu_op_nxt    = '0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_cmd_nxt = i_cmd;
                    w_ra_nxt  = i_ra;
                    w_rb_nxt  = i_rb;
                    w_rc_nxt  = i_rc;
                    w_op_nxt  = i_op_in;
                    case (i_cmd)
                        2'b01:   w_state_nxt = S_MV;
                        2'b10:   w_state_nxt = S_AL_A;
                        default: w_state_nxt = S_DONE;
                    endcase
                end
            end
            S_MV:    w_state_nxt = S_DONE;
            S_AL_A:  w_state_nxt = S_AL_B;
            S_AL_B:  w_state_nxt = S_AL_C;
            S_AL_C:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // Outputs are registered, so decode the state being entered; that
        // puts the strobes in the same cycle as the state they belong to.
        w_busy_nxt = (w_state_nxt != S_IDLE);
        case (w_state_nxt)
            S_MV: begin
                w_r_out_nxt = f_onehot(w_ra_nxt);
                w_r_in_nxt  = f_onehot(w_rc_nxt);
            end
            S_AL_A: begin
                w_r_out_nxt = f_onehot(w_ra_nxt);
                w_y_in_nxt  = 1'b1;
            end
            S_AL_B: begin
                w_r_out_nxt  = f_onehot(w_rb_nxt);
                w_z_in_nxt   = 1'b1;
                w_alu_op_nxt = w_op_nxt;
            end
            S_AL_C: begin
                w_z_low_out_nxt = 1'b1;
                w_r_in_nxt      = f_onehot(w_rc_nxt);
            end
            S_DONE: begin
                w_done_nxt    = 1'b1;
                w_cmd_err_nxt = (w_cmd_nxt == 2'b11);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_state     <= S_IDLE;
            r_cmd       <= '0;
            r_ra        <= '0;
            r_rb        <= '0;
            r_rc        <= '0;
            r_op        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_r_out     <= '0;
            r_r_in      <= '0;
            r_y_in      <= 1'b0;
            r_z_in      <= 1'b0;
            r_z_low_out <= 1'b0;
            r_alu_op    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd       <= w_cmd_nxt;
            r_ra        <= w_ra_nxt;
            r_rb        <= w_rb_nxt;
            r_rc        <= w_rc_nxt;
            r_op        <= w_op_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_cmd_err   <= w_cmd_err_nxt;
            r_r_out     <= w_r_out_nxt;
            r_r_in      <= w_r_in_nxt;
            r_y_in      <= w_y_in_nxt;
            r_z_in      <= w_z_in_nxt;
            r_z_low_out <= w_z_low_out_nxt;
            r_alu_op    <= w_alu_op_nxt;
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_cmd_err   = r_cmd_err;
    assign o_r_out     = r_r_out;
    assign o_r_in      = r_r_in;
    assign o_y_in      = r_y_in;
    assign o_z_in      = r_z_in;
    assign o_z_low_out = r_z_low_out;
    assign o_alu_op    = r_alu_op;

endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// Bench for reg_xfer_sequencer: a command-level model expands every accepted
// command into its list of per-cycle output words, and a compare process
// checks the DUT against that list on every cycle. Directed literal checks
// pin the model to known cycle-by-cycle values.
module tb_reg_xfer_sequencer;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic [15:0] rout;
        logic [15:0] rin;
        logic        y;
        logic        z;
        logic        zlo;
        logic [3:0]  op;
    } exp_t;

    logic        clk;
    logic        clear;
    logic        start;
    logic [1:0]  cmd;
    logic [3:0]  ra, rb, rc, op_in;
    logic        busy, done, cmd_err, y_in, z_in, z_low_out;
    logic [15:0] r_out, r_in;
    logic [3:0]  alu_op;

    int tests;
    int fails;
    int accepts;
    bit chk_en;
    exp_t exp_now;
    exp_t q[$];

    reg_xfer_sequencer #(.NUM_REGS(16), .IDX_W(4), .OP_W(4)) dut (
        .i_clock    (clk),
        .i_clear    (clear),
        .i_start    (start),
        .i_cmd      (cmd),
        .i_ra       (ra),
        .i_rb       (rb),
        .i_rc       (rc),
        .i_op_in    (op_in),
        .o_busy     (busy),
        .o_done     (done),
        .o_cmd_err  (cmd_err),
        .o_r_out    (r_out),
        .o_r_in     (r_in),
        .o_y_in     (y_in),
        .o_z_in     (z_in),
        .o_z_low_out(z_low_out),
        .o_alu_op   (alu_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] bit_of(input logic [3:0] idx);
        return (int'(idx) < 16) ? (16'(1) << idx) : 16'h0000;
    endfunction

    // Command-level model: each accepted command becomes its output words.
    always @(posedge clk) begin
        exp_t e;
        if (clear) begin
            q.delete();
            exp_now = '0;
            chk_en  = 1'b1;
        end else begin
            if (!exp_now.busy && start) begin
                accepts++;
                case (cmd)
                    2'b01: begin
                        e = '0; e.busy = 1; e.rout = bit_of(ra); e.rin = bit_of(rc); q.push_back(e);
                    end
                    2'b10: begin
                        e = '0; e.busy = 1; e.rout = bit_of(ra); e.y = 1; q.push_back(e);
                        e = '0; e.busy = 1; e.rout = bit_of(rb); e.z = 1; e.op = op_in; q.push_back(e);
                        e = '0; e.busy = 1; e.zlo = 1; e.rin = bit_of(rc); q.push_back(e);
                    end
                    default: ;
                endcase
                e = '0; e.busy = 1; e.done = 1; e.err = (cmd == 2'b11); q.push_back(e);
            end
            if (q.size() > 0) exp_now = q.pop_front();
            else              exp_now = '0;
        end
    end

    always @(negedge clk) begin
        exp_t act;
        if (chk_en) begin
            act = {busy, done, cmd_err, r_out, r_in, y_in, z_in, z_low_out, alu_op};
            tests++;
            if (act !== exp_now) begin
                fails++;
                $display("FAIL model_cycle t=%0t actual=%h expected=%h", $time, act, exp_now);
            end
            tests++;
            if ($countones(r_out) > 1 || $countones(r_in) > 1) begin
                fails++;
                $display("FAIL onehot t=%0t actual r_out=%h r_in=%h expected at most one bit each",
                         $time, r_out, r_in);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    // Drive a command in the current cycle; returns one cycle later (k+1).
    task automatic issue(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input logic [3:0] o);
        start = 1'b1; cmd = c; ra = a; rb = b; rc = d; op_in = o;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        int acc0;
        tests = 0; fails = 0; accepts = 0; chk_en = 1'b0; exp_now = '0;
        clear = 1'b1; start = 1'b1; cmd = 2'b10; ra = 4'd1; rb = 4'd2; rc = 4'd3; op_in = 4'd7;
        repeat (2) @(negedge clk);
        chk("rst_outputs_zero",
            64'({busy, done, cmd_err, r_out, r_in, y_in, z_in, z_low_out, alu_op}), 64'd0);

        clear = 1'b0; start = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("rst_no_done", 64'(n), 64'd0);
        chk("rst_idle", 64'(busy), 64'd0);

        // MOVE R1 -> R2
        issue(2'b01, 4'd1, 4'd0, 4'd2, 4'd0);
        chk("mv_r_out", 64'(r_out), 64'h0002);
        chk("mv_r_in", 64'(r_in), 64'h0004);
        @(negedge clk);
        chk("mv_done_busy", 64'({done, busy}), 64'b11);
        @(negedge clk);
        chk("mv_idle", 64'(busy), 64'd0);

        // ALU R5 = R3 op3 R4
        issue(2'b10, 4'd3, 4'd4, 4'd5, 4'h3);
        chk("alu_a", 64'({r_out, y_in, z_in, r_in}), 64'({16'h0008, 1'b1, 1'b0, 16'h0000}));
        @(negedge clk);
        chk("alu_b", 64'({r_out, z_in, alu_op, y_in}), 64'({16'h0010, 1'b1, 4'h3, 1'b0}));
        @(negedge clk);
        chk("alu_c", 64'({z_low_out, r_in, r_out, alu_op}), 64'({1'b1, 16'h0020, 16'h0000, 4'h0}));
        @(negedge clk);
        chk("alu_done", 64'({done, cmd_err, busy}), 64'b101);
        @(negedge clk);

        // Reserved command
        issue(2'b11, 4'd1, 4'd2, 4'd2, 4'd9);
        chk("rsv_done_err", 64'({done, cmd_err, r_out, r_in}), 64'({1'b1, 1'b1, 32'h0}));
        @(negedge clk);
        chk("rsv_single_pulse", 64'({done, cmd_err, busy}), 64'd0);

        // NOP
        issue(2'b00, 4'd1, 4'd2, 4'd2, 4'd0);
        chk("nop_done", 64'({done, cmd_err, r_out, r_in}), 64'({1'b1, 1'b0, 32'h0}));
        @(negedge clk);

        // MOVE with ra == rc and MOVE into R0
        issue(2'b01, 4'd7, 4'd0, 4'd7, 4'd0);
        chk("mv_same_reg", 64'({r_out, r_in}), 64'({16'h0080, 16'h0080}));
        repeat (2) @(negedge clk);
        issue(2'b01, 4'd15, 4'd0, 4'd0, 4'd0);
        chk("mv_to_r0", 64'({r_out, r_in}), 64'({16'h8000, 16'h0001}));
        repeat (2) @(negedge clk);

        // Start held high with alternating commands and changing fields
        acc0 = accepts;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            start = 1'b1;
            cmd   = (i % 2 == 0) ? 2'b01 : 2'b10;
            ra    = 4'($urandom_range(0, 15));
            rb    = 4'($urandom_range(0, 15));
            rc    = 4'($urandom_range(0, 15));
            op_in = 4'($urandom_range(0, 15));
            @(negedge clk);
            if (done) n++;
        end
        start = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("burst_done_per_accept", 64'(n), 64'(accepts - acc0));
        chk("burst_accepted_some", 64'((accepts - acc0) >= 8), 64'd1);

        // Clear during AL_B aborts the command
        issue(2'b10, 4'd1, 4'd2, 4'd3, 4'h5);
        @(negedge clk);
        chk("abort_in_al_b", 64'({z_in, alu_op}), 64'({1'b1, 4'h5}));
        clear = 1'b1;
        @(negedge clk);
        chk("abort_outputs_zero",
            64'({busy, done, cmd_err, r_out, r_in, y_in, z_in, z_low_out, alu_op}), 64'd0);
        clear = 1'b0;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || z_low_out || (r_in != 16'h0)) n++;
        end
        chk("abort_no_tail", 64'(n), 64'd0);
        issue(2'b01, 4'd4, 4'd0, 4'd6, 4'd0);
        chk("post_abort_mv", 64'({r_out, r_in}), 64'({16'h0010, 16'h0040}));
        @(negedge clk);
        chk("post_abort_done", 64'(done), 64'd1);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
